// File: rtl/serdes_pkg.sv
// Shared definitions for the serial encryptor/decryptor cores.
// No logic of its own; constants, receive-state type and key-byte helper.
// Backpressure: not applicable.
package serdes_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    // Key shared with the encryptor wrapper; its low byte (0x34) is the default key byte.
    localparam logic [127:0] DEFAULT_KEY = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E134;

    // Receive state is implied by the bit counter: zero means no partial byte is held.
    typedef enum logic {
        RX_IDLE    = 1'b0,
        RX_COLLECT = 1'b1
    } rx_state_t;

    // Pick byte 'sel' (0..15) out of the 128-bit key.
    function automatic logic [BYTE_W-1:0] key_byte(input logic [127:0] key, input int sel);
        return key[sel*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/serdes_byte_fifo.sv
// Small byte FIFO with a registered head entry (head reads 0 when empty).
// Latency: a push into an empty FIFO shows at the head one cycle later.
// Backpressure: push while full is refused unless a pop happens the same cycle.
module serdes_byte_fifo
    import serdes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              accepted
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wptr, rptr, wptr_nx, rptr_nx;
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] head_nx;
    logic              pop_ok;

    // Extra wrap bit on each pointer separates full from empty.
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign accepted = push && (!full || pop_ok);

    // Next pointers and next head; the head may be the byte being pushed right now.
    always_comb begin
        rptr_nx = rptr + (AW+1)'(pop_ok);
        wptr_nx = wptr + (AW+1)'(accepted);
        head_nx = '0;
        if (rptr_nx != wptr_nx) begin
            if (accepted && (rptr_nx == wptr)) begin
                head_nx = push_data;
            end else begin
                head_nx = mem[rptr_nx[AW-1:0]];
            end
        end
    end

    // Pointer and registered-head update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            head <= '0;
        end else begin
            wptr <= wptr_nx;
            rptr <= rptr_nx;
            head <= head_nx;
        end
    end

    // Storage write; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/secure_serdes_decryptor_core.sv
// Deserialises an MSB-first cipher stream, XORs out the key byte and queues plaintext.
// Latency: out_valid rises one cycle after the 8th qualified bit.
// Backpressure: out_ready pops the FIFO; a byte completing into a full FIFO without a pop is dropped and flags overflow.
module secure_serdes_decryptor_core
    import serdes_pkg::*;
#(
    parameter int KEY_BYTE_SEL = 0,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      key,
    input  logic              cipher_in,
    input  logic              cipher_valid,
    input  logic              sync_clr,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              frame_err,
    output logic [7:0]        byte_count
);

    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic [BYTE_W-1:0]    shreg, shreg_nx, plain;
    logic                 byte_done;
    logic                 fifo_full, fifo_empty, fifo_accepted;
    rx_state_t            rx_state;

    // Next receive state: resync clears, a qualified bit shifts in, the 8th bit completes a byte.
    always_comb begin
        rx_state   = (bit_cnt == '0) ? RX_IDLE : RX_COLLECT;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        byte_done  = 1'b0;
        plain      = {shreg[BYTE_W-2:0], cipher_in} ^ key_byte(key, KEY_BYTE_SEL);
        if (sync_clr) begin
            bit_cnt_nx = '0;
            shreg_nx   = '0;
        end else if (cipher_valid) begin
            shreg_nx   = {shreg[BYTE_W-2:0], cipher_in};
            bit_cnt_nx = bit_cnt + 1'b1;
            byte_done  = (bit_cnt == '1);
        end
    end

    // Receive state, error flags and accepted-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
            byte_count <= '0;
        end else begin
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            frame_err <= sync_clr && (rx_state == RX_COLLECT);
            if (sync_clr) begin
                overflow <= 1'b0;
            end else if (byte_done && !fifo_accepted) begin
                overflow <= 1'b1;
            end
            if (fifo_accepted) begin
                byte_count <= byte_count + 8'd1;
            end
        end
    end

    assign out_valid = !fifo_empty;

    serdes_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_done),
        .push_data (plain),
        .pop       (out_valid && out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .accepted  (fifo_accepted)
    );

    // Full flag is only consumed inside the FIFO's accept rule.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_secure_serdes_decryptor_core.sv
module tb_secure_serdes_decryptor_core;
    import serdes_pkg::*;

    localparam int DEPTH = 2;
    localparam int SEL   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key = DEFAULT_KEY;
    logic         cipher_in = 1'b0;
    logic         cipher_valid = 1'b0;
    logic         sync_clr = 1'b0;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         overflow;
    logic         frame_err;
    logic [7:0]   byte_count;

    always #5 clk = ~clk;

    secure_serdes_decryptor_core #(
        .KEY_BYTE_SEL (SEL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .cipher_in    (cipher_in),
        .cipher_valid (cipher_valid),
        .sync_clr     (sync_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .byte_count   (byte_count)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes assembled from a bit count and integer accumulator, FIFO as a queue.
    logic [7:0] q[$];
    int         nbits = 0;
    int         acc   = 0;
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         m_fe  = 1'b0;
    logic [7:0] kb;
    assign kb = key[SEL*8 +: 8];

    always @(posedge clk) begin
        bit done;
        done = 1'b0;
        if (rst) begin
            q.delete();
            nbits = 0;
            acc   = 0;
            m_cnt = 0;
            m_ovf = 1'b0;
            m_fe  = 1'b0;
        end else begin
            m_fe = 1'b0;
            if (sync_clr) begin
                m_fe  = (nbits != 0);
                nbits = 0;
                acc   = 0;
                m_ovf = 1'b0;
            end else if (cipher_valid) begin
                acc = ((acc << 1) | int'(cipher_in)) & 255;
                nbits++;
                if (nbits == 8) begin
                    done  = 1'b1;
                    nbits = 0;
                end
            end
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (done) begin
                if (q.size() < DEPTH) begin
                    q.push_back(8'(acc) ^ kb);
                    m_cnt = (m_cnt + 1) % 256;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid",  32'(out_valid),  32'(q.size() > 0));
            check("m_out_data",   32'(out_data),   (q.size() > 0) ? 32'(q[0]) : 32'd0);
            check("m_overflow",   32'(overflow),   32'(m_ovf));
            check("m_frame_err",  32'(frame_err),  32'(m_fe));
            check("m_byte_count", 32'(byte_count), 32'(m_cnt));
        end
    end

    task automatic tick(input logic v, input logic b, input logic sc, input logic r);
        @(negedge clk);
        rst          = 1'b0;
        cipher_valid = v;
        cipher_in    = b;
        sync_clr     = sc;
        out_ready    = r;
    endtask

    // Check hand-computed values after the previous edge, then idle the inputs for one cycle.
    task automatic expect_out(input string name, input logic r, input logic v, input logic [7:0] d,
                              input logic [7:0] cnt, input logic ovf, input logic fe);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid),  32'(v));
        check({name, "_data"},  32'(out_data),   32'(d));
        check({name, "_count"}, 32'(byte_count), 32'(cnt));
        check({name, "_ovf"},   32'(overflow),   32'(ovf));
        check({name, "_fe"},    32'(frame_err),  32'(fe));
        rst          = 1'b0;
        cipher_valid = 1'b0;
        cipher_in    = 1'b0;
        sync_clr     = 1'b0;
        out_ready    = r;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r, input logic last_r);
        for (int i = 7; i >= 0; i--) tick(1'b1, b[i], 1'b0, (i == 0) ? last_r : r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        cipher_valid = 1'b0;
        sync_clr     = 1'b0;
        out_ready    = 1'b0;
        expect_out("reset", 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] c52;
        c52 = 8'h52;
        repeat (2) @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Single byte, contiguous bits.
        send_byte(c52, 1'b0, 1'b0);
        expect_out("t1", 1'b1, 1'b1, 8'h66, 8'd1, 1'b0, 1'b0);
        expect_out("t1_pop", 1'b0, 1'b0, 8'h00, 8'd1, 1'b0, 1'b0);

        // Gapped bits: 3 idle cycles between bits 4 and 5.
        do_reset();
        for (int i = 7; i >= 4; i--) tick(1'b1, c52[i], 1'b0, 1'b0);
        repeat (3) expect_out("t2_gap", 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) tick(1'b1, c52[i], 1'b0, 1'b0);
        expect_out("t2", 1'b0, 1'b1, 8'h66, 8'd1, 1'b0, 1'b0);

        // Backpressure: third byte dropped into a full FIFO.
        do_reset();
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        expect_out("t3_full", 1'b1, 1'b1, 8'h66, 8'd2, 1'b1, 1'b0);
        expect_out("t3_pop1", 1'b1, 1'b1, 8'h34, 8'd2, 1'b1, 1'b0);
        expect_out("t3_empty", 1'b0, 1'b0, 8'h00, 8'd2, 1'b1, 1'b0);

        // Full FIFO with a pop on the completing cycle of the third byte.
        do_reset();
        send_byte(8'h52, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b1);
        expect_out("t4_a", 1'b1, 1'b1, 8'h34, 8'd3, 1'b0, 1'b0);
        expect_out("t4_b", 1'b1, 1'b1, 8'hCB, 8'd3, 1'b0, 1'b0);
        expect_out("t4_empty", 1'b0, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0);

        // Resync after 5 bits, then a clean byte, then resync while idle.
        do_reset();
        for (int i = 7; i >= 3; i--) tick(1'b1, c52[i], 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        expect_out("t5_fe", 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1);
        expect_out("t5_fe_end", 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
        send_byte(c52, 1'b0, 1'b0);
        expect_out("t5", 1'b0, 1'b1, 8'h66, 8'd1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("t5_nofe", 1'b0, 1'b1, 8'h66, 8'd1, 1'b0, 1'b0);

        // Reset mid-byte with a non-empty FIFO; rst dominates other inputs.
        for (int i = 7; i >= 5; i--) tick(1'b1, c52[i], 1'b0, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        cipher_valid = 1'b1;
        sync_clr     = 1'b1;
        out_ready    = 1'b1;
        expect_out("t6_rst", 1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0);
        send_byte(c52, 1'b0, 1'b0);
        expect_out("t6", 1'b0, 1'b1, 8'h66, 8'd1, 1'b0, 1'b0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 299) == 0);
            cipher_valid = ($urandom_range(0, 9) < 7);
            cipher_in    = 1'($urandom);
            sync_clr     = ($urandom_range(0, 39) == 0);
            out_ready    = ($urandom_range(0, 9) < ((n / 500) % 2 == 0 ? 2 : 7));
        end
        @(negedge clk);
        rst = 1'b0; cipher_valid = 1'b0; sync_clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/secure_serdes_decryptor_core.md
Name: secure_serdes_decryptor_core

Overview:
- Receive-side neighbour of the serial encryptor core.
- Consumes the MSB-first cipher bit stream, one byte per 8 qualified bits.
- Removes the key byte by XOR and recovers the plaintext combination A^B.
- Buffers recovered bytes in a small FIFO with a valid/ready output handshake, and reports framing and overflow errors for the top-level wrapper.

Parameters:
- KEY_BYTE_SEL, 0: index of the key byte used (key[8*SEL+7 : 8*SEL]), range 0..15. Default matches the encryptor's key[7:0].
- FIFO_DEPTH, 2: output FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- key  in  128  shared key, static during operation
- cipher_in  in  1  serial cipher bit, MSB first
- cipher_valid  in  1  qualifies cipher_in this cycle
- sync_clr  in  1  frame resync; discards the partial byte and clears overflow
- out_data  out  8  recovered byte (A^B) at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- overflow  out  1  sticky: a completed byte was dropped
- frame_err  out  1  one-cycle pulse: sync_clr hit a partial byte
- byte_count  out  8  count of bytes pushed, wraps 255->0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - bit_cnt=0, shift register=0, FIFO empty.
  - out_valid=0, out_data=0, overflow=0, frame_err=0, byte_count=0.
  - rst dominates all other inputs. Reset mid-byte discards the partial byte with no frame_err.
- Receive states, encoded by bit_cnt: IDLE (cnt 0) and COLLECT (cnt 1..7).
  - Each cycle with cipher_valid=1: shreg <= {shreg[6:0], cipher_in}; bit_cnt increments mod 8.
  - cipher_valid=0: hold all state, no timeout.
- Byte completion: the cycle with cipher_valid=1 and bit_cnt==7.
  - plain = {shreg[6:0], cipher_in} ^ key_byte, where key_byte is the byte selected by KEY_BYTE_SEL.
  - plain is pushed the same edge; out_valid rises the next cycle. Latency is 1 cycle from the 8th bit to out_valid.
  - bit_cnt returns to 0, so back-to-back bytes need no gap.
- sync_clr=1 (lower priority than rst only):
  - bit_cnt=0, shreg=0, overflow=0.
  - If bit_cnt!=0 before the edge, frame_err=1 for exactly one cycle.
  - A cipher_valid bit in the same cycle is discarded.
  - sync_clr does not affect FIFO contents or byte_count.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push on byte completion.
  - out_data is the registered head entry; it is 0 when the FIFO is empty.
- Full FIFO:
  - Push with simultaneous pop: both take effect; occupancy unchanged, push accepted.
  - Push with no pop: byte dropped, overflow <= 1, byte_count unchanged.
- Empty FIFO: out_ready is ignored; no underflow.
- byte_count increments only on accepted pushes, modulo 256.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit. full = MSBs differ and LSBs equal; empty = pointers equal.
- overflow stays set until rst or sync_clr.

Decomposition:
- Shared package serdes_pkg holds:
  - BYTE_W=8 and BIT_CNT_W=3.
  - The default 128-bit key constant, shared with the encryptor wrapper.
  - A key_byte(key, sel) extraction function used by both cores.
- One sub-module: serdes_byte_fifo (parameterised DEPTH, 8-bit data, push/pop, full/empty, registered head).
- Deserialiser, XOR and error logic stay in the top core.

Test Plan:
- Single byte, A=0x3C, B=0x5A, key[7:0]=0x34, cipher 0x52 fed MSB first on 8 consecutive valid cycles.
  -> out_valid the cycle after bit 8, out_data=0x66, byte_count=1.
- Gapped bits: same 0x52 byte with cipher_valid deasserted for 3 cycles between bits 4 and 5.
  -> out_data=0x66; no output before the 8th valid bit.
- Backpressure with out_ready=0: three bytes 0x52, 0x00, 0xFF (key byte 0x34).
  -> FIFO holds 0x66, 0x34; third byte dropped; overflow=1; byte_count=2.
  - Then out_ready=1 -> pops 0x66 then 0x34, then out_valid=0.
- Full FIFO with simultaneous push and pop: third byte completes while out_ready=1.
  -> no overflow, byte_count=3, outputs 0x66, 0x34, 0xCB in order.
- Resync: sync_clr after 5 bits, then a full 0x52 byte.
  -> frame_err one-cycle pulse, no byte from the partial bits, then out_data=0x66.
  - sync_clr with bit_cnt=0 -> no frame_err.
- Reset mid-byte and with a non-empty FIFO: rst asserted.
  -> next cycle out_valid=0, overflow=0, byte_count=0, frame_err=0; the next full byte decodes correctly.
